sdram_arbiter: RTL and testbench

Responder side of the SDRAM request/access handshake. It collects the refresh, write and read requests, grants one master at a time with a one-cycle access pulse, and waits for that master's done pulse. While a master is granted, the arbiter drives that master's command, address and bank onto the registered SDRAM command pins. The block sits between the init, auto-refresh, write and read engines and the SDRAM pads.

---
 rtl/sdram_arbiter_if.sv | 58 +++++
 rtl/sdram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
//==============================================================================
// sdram_arbiter_if: engine request/grant/done handshakes and SDRAM pin bundle.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface sdram_arbiter_if;
  logic        INIT_DONE;
  logic [3:0]  INIT_COMMAND;
  logic [11:0] INIT_A_ADDR;
  logic [1:0]  INIT_BANK_ADDR;

  logic        ARF_req;
  logic        ARF_access;
  logic [3:0]  COMMAND_REF;
  logic [11:0] ARF_A_ADDR;
  logic [1:0]  ARF_BANK_ADDR;
  logic        REF_DONE;

  logic        WR_req;
  logic        WR_access;
  logic [3:0]  WR_COMMAND;
  logic [11:0] WR_A_ADDR;
  logic [1:0]  WR_BANK_ADDR;
  logic        WR_DONE;

  logic        RD_req;
  logic        RD_access;
  logic [3:0]  RD_COMMAND;
  logic [11:0] RD_A_ADDR;
  logic [1:0]  RD_BANK_ADDR;
  logic        RD_DONE;

  logic [3:0]  SDRAM_CMD;
  logic [11:0] SDRAM_A;
  logic [1:0]  SDRAM_BA;
  logic        ARB_ERR;

  modport slave (
    input  INIT_DONE, INIT_COMMAND, INIT_A_ADDR, INIT_BANK_ADDR,
    input  ARF_req, COMMAND_REF, ARF_A_ADDR, ARF_BANK_ADDR, REF_DONE,
    input  WR_req, WR_COMMAND, WR_A_ADDR, WR_BANK_ADDR, WR_DONE,
    input  RD_req, RD_COMMAND, RD_A_ADDR, RD_BANK_ADDR, RD_DONE,
    output ARF_access, WR_access, RD_access,
    output SDRAM_CMD, SDRAM_A, SDRAM_BA, ARB_ERR
  );

  modport master (
    output INIT_DONE, INIT_COMMAND, INIT_A_ADDR, INIT_BANK_ADDR,
    output ARF_req, COMMAND_REF, ARF_A_ADDR, ARF_BANK_ADDR, REF_DONE,
    output WR_req, WR_COMMAND, WR_A_ADDR, WR_BANK_ADDR, WR_DONE,
    output RD_req, RD_COMMAND, RD_A_ADDR, RD_BANK_ADDR, RD_DONE,
    input  ARF_access, WR_access, RD_access,
    input  SDRAM_CMD, SDRAM_A, SDRAM_BA, ARB_ERR
  );
endinterface

`default_nettype wire

// File: rtl/sdram_arbiter.sv
//==============================================================================
// sdram_arbiter: fixed-priority (ARF > WR > RD) SDRAM engine arbiter and pin mux.
// Revision: 1.0
//==============================================================================
`default_nettype none

module sdram_arbiter #(
  parameter logic [9:0] TIMEOUT_CYC = 10'd1023,
  parameter logic [3:0] CMD_NOP     = 4'b0111
) (
  input  wire logic        Sys_clk,
  input  wire logic        Rst_n,
  sdram_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_tmo_cnt;
  logic [9:0]  w_tmo_cnt_nxt;
  logic        r_arf_acc, r_wr_acc, r_rd_acc, r_err;
  logic        w_arf_acc_nxt, w_wr_acc_nxt, w_rd_acc_nxt, w_err_nxt;
  logic [3:0]  r_cmd, w_cmd_nxt;
  logic [11:0] r_a, w_a_nxt;
  logic [1:0]  r_ba, w_ba_nxt;
  logic        w_done;
  logic        w_granted;

  always_ff @(posedge Sys_clk) begin
    if (!Rst_n) begin
      r_state   <= ST_INIT;
      r_tmo_cnt <= 10'd0;
      r_arf_acc <= 1'b0;
      r_wr_acc  <= 1'b0;
      r_rd_acc  <= 1'b0;
      r_err     <= 1'b0;
      r_cmd     <= CMD_NOP;
      r_a       <= 12'd0;
      r_ba      <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_arf_acc <= w_arf_acc_nxt;
      r_wr_acc  <= w_wr_acc_nxt;
      r_rd_acc  <= w_rd_acc_nxt;
      r_err     <= w_err_nxt;
      r_cmd     <= w_cmd_nxt;
      r_a       <= w_a_nxt;
      r_ba      <= w_ba_nxt;
    end
  end

  // Only the granted master's done pulse counts.
  always_comb begin
    w_done    = 1'b0;
    w_granted = 1'b0;
    case (r_state)
      ST_AREF:  begin w_done = bus.REF_DONE; w_granted = 1'b1; end
      ST_WRITE: begin w_done = bus.WR_DONE;  w_granted = 1'b1; end
      ST_READ:  begin w_done = bus.RD_DONE;  w_granted = 1'b1; end
      default:  begin w_done = 1'b0;         w_granted = 1'b0; end
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tmo_cnt_nxt = 10'd0;
    w_arf_acc_nxt = 1'b0;
    w_wr_acc_nxt  = 1'b0;
    w_rd_acc_nxt  = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (bus.INIT_DONE) w_state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (bus.ARF_req) begin
          w_state_nxt   = ST_AREF;
          w_arf_acc_nxt = 1'b1;
        end else if (bus.WR_req) begin
          w_state_nxt  = ST_WRITE;
          w_wr_acc_nxt = 1'b1;
        end else if (bus.RD_req) begin
          w_state_nxt  = ST_READ;
          w_rd_acc_nxt = 1'b1;
        end
      end
      default: begin
        // Done takes precedence over a timeout landing in the same cycle.
        if (w_done) begin
          w_state_nxt = ST_ARBIT;
        end else if (r_tmo_cnt == TIMEOUT_CYC) begin
          w_state_nxt = ST_ARBIT;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 10'd1;
        end
      end
    endcase
    if (!w_granted && w_state_nxt != r_state) w_tmo_cnt_nxt = 10'd0;
  end

  always_comb begin
    w_cmd_nxt = CMD_NOP;
    w_a_nxt   = 12'd0;
    w_ba_nxt  = 2'd0;
    case (r_state)
      ST_INIT: begin
        w_cmd_nxt = bus.INIT_COMMAND;
        w_a_nxt   = bus.INIT_A_ADDR;
        w_ba_nxt  = bus.INIT_BANK_ADDR;
      end
      ST_AREF: begin
        w_cmd_nxt = bus.COMMAND_REF;
        w_a_nxt   = bus.ARF_A_ADDR;
        w_ba_nxt  = bus.ARF_BANK_ADDR;
      end
      ST_WRITE: begin
        w_cmd_nxt = bus.WR_COMMAND;
        w_a_nxt   = bus.WR_A_ADDR;
        w_ba_nxt  = bus.WR_BANK_ADDR;
      end
      ST_READ: begin
        w_cmd_nxt = bus.RD_COMMAND;
        w_a_nxt   = bus.RD_A_ADDR;
        w_ba_nxt  = bus.RD_BANK_ADDR;
      end
      default: begin
        w_cmd_nxt = CMD_NOP;
        w_a_nxt   = 12'd0;
        w_ba_nxt  = 2'd0;
      end
    endcase
  end

  assign bus.ARF_access = r_arf_acc;
  assign bus.WR_access  = r_wr_acc;
  assign bus.RD_access  = r_rd_acc;
  assign bus.ARB_ERR    = r_err;
  assign bus.SDRAM_CMD  = r_cmd;
  assign bus.SDRAM_A    = r_a;
  assign bus.SDRAM_BA   = r_ba;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
//==============================================================================
// tb_sdram_arbiter: random + directed stimulus against a per-master reference model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_sdram_arbiter;

  localparam int         TMO = 1023;
  localparam logic [3:0] NOP = 4'b0111;

  logic Sys_clk = 1'b0;
  logic Rst_n   = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  sdram_arbiter_if bus ();

  sdram_arbiter dut (
    .Sys_clk (Sys_clk),
    .Rst_n   (Rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner -2 = initialising, -1 = idle, 0/1/2 = ARF/WR/RD holds the bus.
  int          owner = -2;
  int          age   = 0;
  logic [2:0]  e_acc = 3'b000;
  logic        e_err = 1'b0;
  logic [3:0]  e_cmd = NOP;
  logic [11:0] e_a   = 12'd0;
  logic [1:0]  e_ba  = 2'd0;

  int p_req   = 30;
  bit done_en = 1'b1;
  bit rst_rnd = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0]  req;
    logic [2:0]  done;
    logic [3:0]  mc [3];
    logic [11:0] ma [3];
    logic [1:0]  mb [3];
    req  = {bus.RD_req, bus.WR_req, bus.ARF_req};
    done = {bus.RD_DONE, bus.WR_DONE, bus.REF_DONE};
    mc[0] = bus.COMMAND_REF; ma[0] = bus.ARF_A_ADDR; mb[0] = bus.ARF_BANK_ADDR;
    mc[1] = bus.WR_COMMAND;  ma[1] = bus.WR_A_ADDR;  mb[1] = bus.WR_BANK_ADDR;
    mc[2] = bus.RD_COMMAND;  ma[2] = bus.RD_A_ADDR;  mb[2] = bus.RD_BANK_ADDR;
    e_acc = 3'b000;
    e_err = 1'b0;
    if (!Rst_n) begin
      owner = -2; age = 0;
      e_cmd = NOP; e_a = 12'd0; e_ba = 2'd0;
    end else begin
      if (owner == -2) begin
        e_cmd = bus.INIT_COMMAND; e_a = bus.INIT_A_ADDR; e_ba = bus.INIT_BANK_ADDR;
      end else if (owner == -1) begin
        e_cmd = NOP; e_a = 12'd0; e_ba = 2'd0;
      end else begin
        e_cmd = mc[owner]; e_a = ma[owner]; e_ba = mb[owner];
      end
      if (owner == -2) begin
        if (bus.INIT_DONE) owner = -1;
      end else if (owner == -1) begin
        for (int m = 0; m < 3; m++) begin
          if (owner == -1 && req[m]) begin
            owner = m; age = 0; e_acc[m] = 1'b1;
          end
        end
      end else if (done[owner]) begin
        owner = -1;
      end else if (age == TMO) begin
        owner = -1; e_err = 1'b1;
      end else begin
        age++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge Sys_clk);
    model_step();
    @(negedge Sys_clk);
    check("cycle", {bus.ARF_access, bus.WR_access, bus.RD_access, bus.ARB_ERR,
                    bus.SDRAM_CMD, bus.SDRAM_A, bus.SDRAM_BA},
                   {e_acc[0], e_acc[1], e_acc[2], e_err, e_cmd, e_a, e_ba});
    check("onehot", 64'($countones({bus.ARF_access, bus.WR_access, bus.RD_access}) <= 1), 64'd1);
  endtask

  task automatic set_req(input int m, input logic v);
    if (m == 0) bus.ARF_req = v; else if (m == 1) bus.WR_req = v; else bus.RD_req = v;
  endtask

  task automatic set_done(input int m, input logic v);
    if (m == 0) bus.REF_DONE = v; else if (m == 1) bus.WR_DONE = v; else bus.RD_DONE = v;
  endtask

  task automatic drive_rand();
    bus.INIT_DONE      = ($urandom_range(7) == 0);
    bus.INIT_COMMAND   = 4'($urandom);
    bus.INIT_A_ADDR    = 12'($urandom);
    bus.INIT_BANK_ADDR = 2'($urandom);
    bus.ARF_req        = ($urandom_range(99) < p_req);
    bus.WR_req         = ($urandom_range(99) < p_req);
    bus.RD_req         = ($urandom_range(99) < p_req);
    bus.COMMAND_REF    = 4'($urandom);
    bus.ARF_A_ADDR     = 12'($urandom);
    bus.ARF_BANK_ADDR  = 2'($urandom);
    bus.WR_COMMAND     = 4'($urandom);
    bus.WR_A_ADDR      = 12'($urandom);
    bus.WR_BANK_ADDR   = 2'($urandom);
    bus.RD_COMMAND     = 4'($urandom);
    bus.RD_A_ADDR      = 12'($urandom);
    bus.RD_BANK_ADDR   = 2'($urandom);
    bus.REF_DONE       = done_en && ($urandom_range(3) == 0);
    bus.WR_DONE        = done_en && ($urandom_range(3) == 0);
    bus.RD_DONE        = done_en && ($urandom_range(3) == 0);
    if (rst_rnd) Rst_n = ($urandom_range(299) != 0);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      drive_rand();
      cycle();
    end
  endtask

  task automatic quiet_inputs();
    bus.INIT_DONE = 1'b0;
    bus.ARF_req = 1'b0; bus.WR_req = 1'b0; bus.RD_req = 1'b0;
    bus.REF_DONE = 1'b0; bus.WR_DONE = 1'b0; bus.RD_DONE = 1'b0;
  endtask

  task automatic wait_grant(input int m, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      seen = (m == 0) ? bus.ARF_access : (m == 1) ? bus.WR_access : bus.RD_access;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    drive_rand();
    quiet_inputs();
    Rst_n = 1'b0;
    cycle();
    cycle();
    check("rst_cmd", 64'(bus.SDRAM_CMD), 64'(NOP));
    check("rst_a_ba", {bus.SDRAM_A, bus.SDRAM_BA}, 64'd0);
    check("rst_acc_err", {bus.ARF_access, bus.WR_access, bus.RD_access, bus.ARB_ERR}, 64'd0);

    Rst_n = 1'b1;
    bus.INIT_COMMAND = 4'b0010;
    cycle();
    check("init_pass", 64'(bus.SDRAM_CMD), 64'h2);
    bus.INIT_DONE = 1'b1;
    cycle();
    bus.INIT_DONE = 1'b0;
    cycle();
    check("arbit_nop", 64'(bus.SDRAM_CMD), 64'(NOP));

    bus.ARF_req = 1'b1;
    bus.COMMAND_REF = 4'b0001;
    cycle();
    check("arf_acc", 64'(bus.ARF_access), 64'd1);
    bus.ARF_req = 1'b0;
    cycle();
    check("arf_acc_pulse", 64'(bus.ARF_access), 64'd0);
    check("arf_cmd", 64'(bus.SDRAM_CMD), 64'h1);
    bus.REF_DONE = 1'b1;
    cycle();
    bus.REF_DONE = 1'b0;
    cycle();
    check("arf_back_nop", 64'(bus.SDRAM_CMD), 64'(NOP));

    // All three request together: expect ARF, WR, RD order.
    bus.ARF_req = 1'b1; bus.WR_req = 1'b1; bus.RD_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      int who;
      who = -1;
      for (int k = 0; k < 10 && who < 0; k++) begin
        cycle();
        if (bus.ARF_access) who = 0;
        else if (bus.WR_access) who = 1;
        else if (bus.RD_access) who = 2;
      end
      check("prio_order", 64'(who), 64'(g));
      if (who >= 0) begin
        set_req(who, 1'b0);
        set_done(who, 1'b1);
        cycle();
        set_done(who, 1'b0);
      end
    end
    cycle();

    rand_phase(3000);

    // Timeout: WR never finishes, RD waiting behind it.
    quiet_inputs();
    Rst_n = 1'b1;
    for (int k = 0; k < 8 && owner != -1; k++) begin
      if (owner == -2) bus.INIT_DONE = 1'b1;
      else if (owner >= 0) set_done(owner, 1'b1);
      cycle();
      quiet_inputs();
    end
    check("tmo_idle", 64'(owner), -64'sd1);
    done_en = 1'b0;
    bus.WR_req = 1'b1; bus.RD_req = 1'b1;
    wait_grant(1, "tmo_wr_grant");
    bus.WR_req = 1'b0;
    begin
      int n;
      n = 0;
      for (int k = 0; k < 1100 && !bus.ARB_ERR; k++) begin
        cycle();
        n++;
      end
      check("tmo_len", 64'(n), 64'(TMO + 1));
    end
    check("tmo_err", 64'(bus.ARB_ERR), 64'd1);
    cycle();
    check("tmo_err_pulse", 64'(bus.ARB_ERR), 64'd0);
    check("tmo_next_rd", 64'(bus.RD_access), 64'd1);
    bus.RD_req = 1'b0;

    // RD_DONE arrives in the very cycle the grant would time out.
    begin
      bit fired;
      fired = 1'b0;
      for (int k = 0; k < 1100 && !fired; k++) begin
        if (owner == 2 && age == TMO) begin
          bus.RD_DONE = 1'b1;
          fired = 1'b1;
        end
        cycle();
        bus.RD_DONE = 1'b0;
      end
      check("collide_fired", 64'(fired), 64'd1);
      check("collide_no_err", 64'(bus.ARB_ERR), 64'd0);
    end
    cycle();
    check("collide_nop", 64'(bus.SDRAM_CMD), 64'(NOP));

    // Reset in the middle of a write grant.
    bus.WR_req = 1'b1;
    wait_grant(1, "rstmid_grant");
    bus.WR_req = 1'b0;
    bus.WR_COMMAND = 4'b0100;
    cycle();
    Rst_n = 1'b0;
    cycle();
    check("rstmid_acc", 64'(bus.WR_access), 64'd0);
    check("rstmid_cmd", 64'(bus.SDRAM_CMD), 64'(NOP));
    Rst_n = 1'b1;
    bus.WR_DONE = 1'b1;
    bus.INIT_COMMAND = 4'b0011;
    cycle();
    bus.WR_DONE = 1'b0;
    cycle();
    check("rstmid_init", 64'(bus.SDRAM_CMD), 64'h3);

    done_en = 1'b1;
    rst_rnd = 1'b1;
    rand_phase(2000);
    rst_rnd = 1'b0;
    Rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
